k12_nonce_dispatcher: RTL
=========================

Name: k12_nonce_dispatcher

Overview:
Upstream job and nonce sequencer for the K12_PoW hasher. It accepts a mining job (blob, target, start nonce, nonce count) from the host side, issues one `load` pulse per nonce to the hasher at a fixed interval, and tags each hasher `store` with the nonce that produced it. Winning nonces go into a small FIFO for host readout.

Parameters:
HASH_LATENCY, 30, cycles from hs_load sampled high to the matching hs_store cycle of K12_PoW; minimum 1.
ISSUE_INTERVAL, 30, cycles between consecutive hs_load pulses; 1 means fully pipelined; minimum 1.
SHARE_FIFO_DEPTH, 4, winning-nonce FIFO entries; power of 2, minimum 2.

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  asynchronous, active-low reset.
job_valid  in  1  job offered.
job_ready  out  1  high only in IDLE.
job_blob  in  576  hashing blob.
job_target  in  64  share target.
job_nonce_start  in  64  first nonce.
job_count  in  32  number of nonces to hash.
abort  in  1  cancel the current job.
hs_load  out  1  one-cycle load pulse to the hasher.
hs_blob  out  576  latched blob, stable for the whole job.
hs_target  out  64  latched target, stable for the whole job.
hs_nonce  out  64  nonce; valid while hs_load is high.
hs_store  in  1  hasher share flag.
share_valid  out  1  FIFO non-empty.
share_ready  in  1  pop the FIFO head.
share_nonce  out  64  FIFO head nonce.
share_overflow  out  1  sticky: a share was dropped.
busy  out  1  high in ISSUE and DRAIN.
done  out  1  one-cycle pulse when a job completes normally.

Behaviour:
- Reset values: all registered outputs 0, FIFO empty, delay line invalid, state IDLE. job_ready is therefore 1 once reset releases.
- IDLE state:
  - Handshake completes when job_valid and job_ready are both high. The job registers latch on that cycle and share_overflow clears.
  - If job_count is 0, pulse done on the next cycle and stay in IDLE.
  - Otherwise go to ISSUE.
- ISSUE state:
  - First hs_load is on the cycle after acceptance, with hs_nonce = job_nonce_start.
  - Each further hs_load follows the previous one by exactly ISSUE_INTERVAL cycles.
  - The nonce increments by 1 modulo 2^64: 0xFFFFFFFFFFFFFFFF wraps to 0 without stopping.
  - The remaining count decrements per issue. When the last nonce is issued, go to DRAIN.
- Tag delay line:
  - HASH_LATENCY stages of {valid, nonce}, shifting every cycle.
  - The head is loaded with {hs_load, hs_nonce}.
  - When hs_store is high and the tail is valid, the tail nonce is pushed into the FIFO.
  - hs_store with an invalid tail is ignored.
- DRAIN state:
  - Stay in DRAIN until the delay line holds no valid entries.
  - Then pulse done for 1 cycle, clear busy, and return to IDLE.
  - A store arriving on the same cycle as the final tail entry is still captured.
- abort:
  - From any state, abort returns to IDLE on the next cycle and clears all delay-line valid bits.
  - No done pulse.
  - FIFO contents are kept.
  - abort in IDLE has no effect.
  - abort takes priority over a same-cycle job acceptance.
- FIFO:
  - First-word-fall-through.
  - Pop occurs on share_valid and share_ready.
  - A push when full is dropped and sets share_overflow, unless a pop happens in the same cycle; then the push is accepted.
  - A simultaneous push and pop when empty: the push is kept and share_valid rises next cycle.
- Mid-operation reset clears everything immediately, including FIFO and sticky flags.

Optional Feature:
K12_DISPATCH_STATS_EN:
- When defined, adds output stat_hashes (48 bits).
  - Counts hs_load pulses since reset, saturating at all-ones.
  - Not cleared by abort or by a new job.
- When undefined, the port and counter are absent, and all other behaviour is identical.

Test Plan:
1. Defaults, job_count=1, job_nonce_start=0x00000002c9146afa, hs_store pulsed 30 cycles after hs_load -> share_nonce=0x00000002c9146afa, share_valid=1, done 1 cycle after the tail clears, busy=0.
2. ISSUE_INTERVAL=1, HASH_LATENCY=30, job_count=8 from 0x10, hs_store high only 33 cycles after the first load -> exactly one share, nonce 0x13.
3. job_count=3 starting at 0xFFFFFFFFFFFFFFFE -> hs_nonce sequence FFFFFFFFFFFFFFFE, FFFFFFFFFFFFFFFF, 0000000000000000, then done.
4. SHARE_FIFO_DEPTH=4, share_ready=0, 5 stores on valid tails -> FIFO holds the first 4 nonces, share_overflow=1. Next accepted job clears share_overflow only.
5. abort 5 cycles into a job_count=100 job -> IDLE next cycle, no done, late hs_store ignored, job_ready=1.
6. job_count=0 -> no hs_load, done one cycle after acceptance. With K12_DISPATCH_STATS_EN, stat_hashes is unchanged.

Source files
------------

// File: rtl/k12_nonce_dispatcher.sv
// k12_nonce_dispatcher: K12_PoW job/nonce sequencer with tag delay line and share FIFO; K12_DISPATCH_STATS_EN adds stat_hashes
module k12_nonce_dispatcher #(
  parameter int HASH_LATENCY     = 30,
  parameter int ISSUE_INTERVAL   = 30,
  parameter int SHARE_FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [575:0] job_blob,
  input  logic [63:0]  job_target,
  input  logic [63:0]  job_nonce_start,
  input  logic [31:0]  job_count,
  input  logic         abort,
  output logic         hs_load,
  output logic [575:0] hs_blob,
  output logic [63:0]  hs_target,
  output logic [63:0]  hs_nonce,
  input  logic         hs_store,
  output logic         share_valid,
  input  logic         share_ready,
  output logic [63:0]  share_nonce,
  output logic         share_overflow,
  output logic         busy,
  output logic         done
`ifdef K12_DISPATCH_STATS_EN
  ,
  output logic [47:0]  stat_hashes
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  localparam int TW = $clog2(ISSUE_INTERVAL + 1);
  localparam int AW = $clog2(SHARE_FIFO_DEPTH);
  state_t state;
  logic [TW-1:0] tmr;
  logic [31:0] rem;
  logic [HASH_LATENCY-1:0] vld;
  logic [63:0] tag [HASH_LATENCY];
  logic [63:0] mem [SHARE_FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic kill, accept, fire, push, pop, full, wr;
  assign job_ready = state == IDLE;
  assign busy = !job_ready;
  assign kill = abort && state != IDLE;
  assign accept = job_valid && state == IDLE && !abort;
  assign fire = tmr == TW'(ISSUE_INTERVAL - 1);
  assign push = hs_store && vld[HASH_LATENCY-1];
  assign pop = share_valid && share_ready;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign wr = push && (!full || pop);
  assign share_valid = wp != rp;
  assign share_nonce = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hs_load <= 1'b0;
      hs_nonce <= '0;
      hs_blob <= '0;
      hs_target <= '0;
      done <= 1'b0;
      rem <= '0;
      tmr <= '0;
    end else begin
      hs_load <= 1'b0;
      done <= 1'b0;
      if (kill) state <= IDLE;
      else case (state)
        IDLE: if (accept) begin
          hs_blob <= job_blob;
          hs_target <= job_target;
          hs_nonce <= job_nonce_start;
          rem <= job_count - 1;
          tmr <= '0;
          hs_load <= job_count != 0;
          done <= job_count == 0;
          state <= job_count == 0 ? IDLE : job_count == 1 ? DRAIN : ISSUE;
        end
        ISSUE: if (fire) begin
          hs_load <= 1'b1;
          hs_nonce <= hs_nonce + 1;
          rem <= rem - 1;
          tmr <= '0;
          if (rem == 1) state <= DRAIN;
        end else tmr <= tmr + 1'b1;
        DRAIN: if (!hs_load && vld == '0) begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // the load pulse itself counts as in flight until it enters the delay line
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld <= '0;
    else if (kill) vld <= '0;
    else begin
      for (int i = HASH_LATENCY - 1; i > 0; i--) vld[i] <= vld[i-1];
      vld[0] <= hs_load;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = HASH_LATENCY - 1; i > 0; i--) tag[i] <= tag[i-1];
    tag[0] <= hs_nonce;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      share_overflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      share_overflow <= accept ? 1'b0 : share_overflow | (push && full && !pop);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp[AW-1:0]] <= tag[HASH_LATENCY-1];
`ifdef K12_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stat_hashes <= '0;
    else if (hs_load && !(&stat_hashes)) stat_hashes <= stat_hashes + 1'b1;
  end
`endif
endmodule
